// File: rtl/macro_arbiter_rr_pkg.sv
// ============================================================================
//  Module  : macro_arbiter_rr_pkg
//  Purpose : Shared definitions for the round-robin arbiter: grant-index width
//            derivation and the lock state encoding used when the optional
//            burst-lock feature (MACRO_ARBITER_RR_LOCK_EN) is built in.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package macro_arbiter_rr_pkg;

    // Width of a grant index able to address COUNT requesters.
    function automatic int index_width(input int count);
        return (count <= 1) ? 1 : $clog2(count);
    endfunction

    // Burst-lock state. LOCKED carries the locked requester index in a
    // separate register alongside the state.
    typedef enum logic [0:0] {
        LOCK_UNLOCKED = 1'b0,
        LOCK_LOCKED   = 1'b1
    } lock_state_e;

endpackage

`default_nettype wire

// File: rtl/macro_reduction_or.sv
// ============================================================================
//  Module  : macro_reduction_or
//  Purpose : Bitwise OR of INPUT_COUNT slices, each INPUT_WIDTH bits wide.
//            With at most one slice non-zero this acts as a one-hot mux.
//  Ports   : data_i  in   INPUT_WIDTH*INPUT_COUNT  slice i at [i*W +: W]
//            data_o  out  INPUT_WIDTH              OR of all slices
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module macro_reduction_or #(
    parameter int INPUT_WIDTH = 32,
    parameter int INPUT_COUNT = 4
) (
    input  logic [INPUT_WIDTH*INPUT_COUNT-1:0] data_i,
    output logic [INPUT_WIDTH-1:0]             data_o
);

    always_comb begin
        data_o = '0;
        for (int i = 0; i < INPUT_COUNT; i++) begin
            data_o = data_o | data_i[i*INPUT_WIDTH +: INPUT_WIDTH];
        end
    end

endmodule

`default_nettype wire

// File: rtl/macro_arbiter_rr.sv
// ============================================================================
//  Module  : macro_arbiter_rr
//  Purpose : Round-robin arbiter sharing one registered valid/ready output
//            channel among INPUT_COUNT requesters. One-cycle latency, full
//            throughput (drain and reload in the same cycle).
//  Option  : `define MACRO_ARBITER_RR_LOCK_EN adds burst locking: a beat with
//            req_last=0 locks the channel to its requester until a beat with
//            req_last=1 from that requester is accepted.
//  Ports   : clk        in   1        clock, rising edge
//            resetn     in   1        asynchronous active-low reset
//            req_valid  in   N        per-requester valid
//            req_data   in   W*N      requester i payload at [i*W +: W]
//            req_last   in   N        end of burst (lock feature only)
//            req_ready  out  N        one-hot accept, combinational
//            out_valid  out  1        output register holds data
//            out_data   out  W        registered payload
//            out_index  out  IW       registered source index
//            out_ready  in   1        downstream accept
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module macro_arbiter_rr
    import macro_arbiter_rr_pkg::*;
#(
    parameter int INPUT_WIDTH = 32,
    parameter int INPUT_COUNT = 4,
    parameter int INDEX_WIDTH = index_width(INPUT_COUNT)
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic [INPUT_COUNT-1:0]             req_valid,
    input  logic [INPUT_WIDTH*INPUT_COUNT-1:0] req_data,
    input  logic [INPUT_COUNT-1:0]             req_last,
    output logic [INPUT_COUNT-1:0]             req_ready,
    output logic                               out_valid,
    output logic [INPUT_WIDTH-1:0]             out_data,
    output logic [INDEX_WIDTH-1:0]             out_index,
    input  logic                               out_ready
);

    localparam logic [INDEX_WIDTH:0]   c_COUNT    = (INDEX_WIDTH+1)'(INPUT_COUNT);
    localparam logic [INDEX_WIDTH-1:0] c_LAST_IDX = INDEX_WIDTH'(INPUT_COUNT - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                   out_valid_q, out_valid_d;
    logic [INPUT_WIDTH-1:0] out_data_q,  out_data_d;
    logic [INDEX_WIDTH-1:0] out_index_q, out_index_d;
    logic [INDEX_WIDTH-1:0] ptr_q,       ptr_d;

    logic [INPUT_COUNT-1:0]             w_eligible;
    logic                               w_found;
    logic [INDEX_WIDTH-1:0]             w_winner;
    logic [INDEX_WIDTH:0]               w_pos;
    logic                               w_load_en;
    logic [INPUT_COUNT-1:0]             w_grant;
    logic                               w_xfer;
    logic                               w_ptr_adv;
    logic [INDEX_WIDTH-1:0]             w_next_ptr;
    logic [INPUT_WIDTH*INPUT_COUNT-1:0] w_masked;
    logic [INPUT_WIDTH-1:0]             w_sel_data;

    // ------------------------------------------------------------------------
    // Optional burst lock
    // ------------------------------------------------------------------------
`ifdef MACRO_ARBITER_RR_LOCK_EN
    lock_state_e            lock_state_q, lock_state_d;
    logic [INDEX_WIDTH-1:0] lock_idx_q,   lock_idx_d;
    logic [INPUT_COUNT-1:0] w_lock_mask;

    // While locked only the lock owner is visible to the priority search,
    // so other requesters wait even if the owner deasserts valid.
    always_comb begin
        w_lock_mask             = '0;
        w_lock_mask[lock_idx_q] = 1'b1;
        w_eligible              = (lock_state_q == LOCK_LOCKED) ? (req_valid & w_lock_mask)
                                                                : req_valid;
    end

    always_comb begin
        lock_state_d = lock_state_q;
        lock_idx_d   = lock_idx_q;
        w_ptr_adv    = 1'b0;
        case (lock_state_q)
            LOCK_UNLOCKED: begin
                if (w_xfer) begin
                    w_ptr_adv = 1'b1;
                    if (!req_last[w_winner]) begin
                        lock_state_d = LOCK_LOCKED;
                        lock_idx_d   = w_winner;
                    end
                end
            end
            LOCK_LOCKED: begin
                // Pointer stays put inside a burst; it advances past the
                // owner only when the burst closes.
                if (w_xfer && req_last[lock_idx_q]) begin
                    lock_state_d = LOCK_UNLOCKED;
                    w_ptr_adv    = 1'b1;
                end
            end
            default: lock_state_d = LOCK_UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_state_q <= LOCK_UNLOCKED;
            lock_idx_q   <= '0;
        end else begin
            lock_state_q <= lock_state_d;
            lock_idx_q   <= lock_idx_d;
        end
    end
`else
    logic w_unused_last;

    assign w_unused_last = ^req_last;
    assign w_eligible    = req_valid;
    assign w_ptr_adv     = w_xfer;
`endif

    // ------------------------------------------------------------------------
    // Round-robin priority search: first eligible requester at or after ptr,
    // wrapping modulo INPUT_COUNT (need not be a power of two).
    // ------------------------------------------------------------------------
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_pos    = '0;
        for (int k = 0; k < INPUT_COUNT; k++) begin
            w_pos = {1'b0, ptr_q} + (INDEX_WIDTH+1)'(k);
            if (w_pos >= c_COUNT) begin
                w_pos = w_pos - c_COUNT;
            end
            if (!w_found && w_eligible[w_pos[INDEX_WIDTH-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_pos[INDEX_WIDTH-1:0];
            end
        end
    end

    // resetn gates the load so req_ready is held low throughout reset.
    assign w_load_en = resetn & (~out_valid_q | out_ready);

    always_comb begin
        w_grant = '0;
        if (w_load_en && w_found) begin
            w_grant[w_winner] = 1'b1;
        end
    end

    assign req_ready  = w_grant;
    assign w_xfer     = |w_grant;
    assign w_next_ptr = (w_winner == c_LAST_IDX) ? '0 : w_winner + INDEX_WIDTH'(1);

    // ------------------------------------------------------------------------
    // Winner payload: mask each slice by its grant bit, then OR-reduce.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < INPUT_COUNT; gi++) begin : g_mask
        assign w_masked[gi*INPUT_WIDTH +: INPUT_WIDTH] =
            req_data[gi*INPUT_WIDTH +: INPUT_WIDTH] & {INPUT_WIDTH{w_grant[gi]}};
    end

    macro_reduction_or #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .INPUT_COUNT (INPUT_COUNT)
    ) u_reduce (
        .data_i (w_masked),
        .data_o (w_sel_data)
    );

    // ------------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        ptr_d       = ptr_q;
        if (w_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = w_sel_data;
            out_index_d = w_winner;
        end else if (out_ready) begin
            // Drained with nothing to refill; data and index keep last beat.
            out_valid_d = 1'b0;
        end
        if (w_ptr_adv) begin
            ptr_d = w_next_ptr;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;

endmodule

`default_nettype wire

// File: tb/tb_macro_arbiter_rr.sv
// ============================================================================
//  Module  : tb_macro_arbiter_rr
//  Purpose : Self-checking bench for macro_arbiter_rr: directed scenarios
//            pinned with literal expectations, then randomized traffic
//            compared every cycle against a behavioural model.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_macro_arbiter_rr;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           resetn;
    logic [N-1:0]   req_valid;
    logic [W*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [IW-1:0]  out_index;
    logic           out_ready;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: state the DUT must hold after the coming edge.
    int           m_ptr;
    bit           m_ov;
    logic [W-1:0] m_od;
    int           m_oi;
    bit           m_locked;
    int           m_lidx;
    logic [N-1:0] m_xfer = '0;
    logic [N-1:0] e_rdy;
    int           e_win;
    bit           e_found;
    bit           e_load;
    int           e_c;

    // Literal expectations for the next falling edge.
    bit           lit_en = 1'b0;
    string        lit_name;
    bit           lit_ov;
    int           lit_oi;
    logic [W-1:0] lit_od;
    logic [N-1:0] lit_rdy;

    macro_arbiter_rr #(
        .INPUT_WIDTH (W),
        .INPUT_COUNT (N),
        .INDEX_WIDTH (IW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_index (out_index),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Requesters keep valid and data stable until accepted.
    for (genvar gi = 0; gi < N; gi++) begin : g_req_stable
        a_hold: assert property (@(posedge clk) disable iff (!resetn)
            (req_valid[gi] && !req_ready[gi]) |=> (req_valid[gi] && $stable(req_data[gi*W +: W])));
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Compare process: DUT against model (and literals) at every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                m_ptr    = 0;
                m_ov     = 1'b0;
                m_od     = '0;
                m_oi     = 0;
                m_locked = 1'b0;
                m_lidx   = 0;
                m_xfer   = '0;
                e_rdy    = '0;
                e_found  = 1'b0;
                e_load   = 1'b0;
                e_win    = 0;
            end else begin
                e_load  = !m_ov || out_ready;
                e_found = 1'b0;
                e_win   = 0;
                for (int k = 0; k < N; k++) begin
                    e_c = (m_ptr + k) % N;
                    if (!e_found && req_valid[e_c] && (!m_locked || e_c == m_lidx)) begin
                        e_found = 1'b1;
                        e_win   = e_c;
                    end
                end
                e_rdy = '0;
                if (e_load && e_found) e_rdy[e_win] = 1'b1;
            end

            chk("model_ready", 64'(req_ready), 64'(e_rdy));
            chk("model_valid", 64'(out_valid), 64'(m_ov));
            chk("model_data",  64'(out_data),  64'(m_od));
            chk("model_index", 64'(out_index), 64'(m_oi));

            if (lit_en) begin
                chk({lit_name, "_ready"}, 64'(req_ready), 64'(lit_rdy));
                chk({lit_name, "_valid"}, 64'(out_valid), 64'(lit_ov));
                chk({lit_name, "_data"},  64'(out_data),  64'(lit_od));
                chk({lit_name, "_index"}, 64'(out_index), 64'(lit_oi));
            end

            if (resetn) begin
                if (e_load && e_found) begin
                    m_ov = 1'b1;
                    m_od = req_data[e_win*W +: W];
                    m_oi = e_win;
`ifdef MACRO_ARBITER_RR_LOCK_EN
                    if (!m_locked) begin
                        if (!req_last[e_win]) begin
                            m_locked = 1'b1;
                            m_lidx   = e_win;
                        end
                        m_ptr = (e_win + 1) % N;
                    end else if (req_last[e_win]) begin
                        m_locked = 1'b0;
                        m_ptr    = (e_win + 1) % N;
                    end
`else
                    m_ptr = (e_win + 1) % N;
`endif
                    m_xfer = e_rdy;
                end else begin
                    m_xfer = '0;
                    if (out_ready) m_ov = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        lit_en = 1'b0;
    endtask

    task automatic lit(input string name, input bit ov, input int oi,
                       input logic [W-1:0] od, input logic [N-1:0] rdy);
        lit_name = name;
        lit_ov   = ov;
        lit_oi   = oi;
        lit_od   = od;
        lit_rdy  = rdy;
        lit_en   = 1'b1;
    endtask

    task automatic set_data(input int i, input logic [W-1:0] d);
        req_data[i*W +: W] = d;
    endtask

    initial begin
        resetn    = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '1;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) set_data(i, 32'hA0 + 32'(i));
        req_valid = 4'hF;
        out_ready = 1'b1;
        lit("reset", 1'b0, 0, 32'h0, 4'b0000);

        // Round robin over four continuously valid requesters.
        step(); resetn = 1'b1;     lit("release", 1'b0, 0, 32'h0,  4'b0001);
        step();                    lit("rr0", 1'b1, 0, 32'hA0, 4'b0010);
        step();                    lit("rr1", 1'b1, 1, 32'hA1, 4'b0100);
        step();                    lit("rr2", 1'b1, 2, 32'hA2, 4'b1000);
        step();                    lit("rr3", 1'b1, 3, 32'hA3, 4'b0001);
        step(); req_valid[0] = 0;  lit("rr4", 1'b1, 0, 32'hA0, 4'b0010);
        step(); req_valid[1] = 0;  lit("rr5", 1'b1, 1, 32'hA1, 4'b0100);
        step(); req_valid[2] = 0;  lit("rr6", 1'b1, 2, 32'hA2, 4'b1000);
        step(); req_valid[3] = 0;  lit("rr7", 1'b1, 3, 32'hA3, 4'b0000);

        // Drain without refill, then a single requester against a stalled sink.
        step(); set_data(2, 32'h55); req_valid = 4'b0100; out_ready = 1'b0;
                                   lit("drain",   1'b0, 3, 32'hA3, 4'b0100);
        step();                    lit("hold55",  1'b1, 2, 32'h55, 4'b0000);
        step();                    lit("stall",   1'b1, 2, 32'h55, 4'b0000);
        step(); out_ready = 1'b1;  lit("unstall", 1'b1, 2, 32'h55, 4'b0100);

        // Pointer at 3: requester 3 ahead of 0.
        step(); req_valid = 4'b1001; set_data(0, 32'h10); set_data(3, 32'h33);
                                   lit("ptr3", 1'b1, 2, 32'h55, 4'b1000);
        step(); req_valid[3] = 0;  lit("w3",   1'b1, 3, 32'h33, 4'b0001);
        step(); req_valid[3] = 1;  lit("w0",   1'b1, 0, 32'h10, 4'b1000);

        // Asynchronous reset with a beat in the output register.
        step(); resetn = 1'b0;     lit("arst",       1'b0, 0, 32'h0,  4'b0000);
        step(); resetn = 1'b1;     lit("rel2",       1'b0, 0, 32'h0,  4'b0001);
        step(); req_valid[0] = 0;  lit("after_rst",  1'b1, 0, 32'h10, 4'b1000);
        step(); req_valid[3] = 0;  lit("after_rst3", 1'b1, 3, 32'h33, 4'b0000);

`ifdef MACRO_ARBITER_RR_LOCK_EN
        // Requester 1 bursts three beats while requester 0 stays valid.
        step(); req_valid = 4'b0001; set_data(0, 32'hB0); req_last = '1;
                                   lit("lk_idle", 1'b0, 3, 32'h33, 4'b0001);
        step(); req_valid = 4'b0011; set_data(1, 32'hC1); req_last[1] = 1'b0;
                                   lit("lk_b0",   1'b1, 0, 32'hB0, 4'b0010);
        step(); set_data(1, 32'hC2);
                                   lit("lk_c1",   1'b1, 1, 32'hC1, 4'b0010);
        step(); set_data(1, 32'hC3); req_last[1] = 1'b1;
                                   lit("lk_c2",   1'b1, 1, 32'hC2, 4'b0010);
        step(); req_valid[1] = 0;  lit("lk_c3",   1'b1, 1, 32'hC3, 4'b0001);
        step(); req_valid = '0;    lit("lk_rel",  1'b1, 0, 32'hB0, 4'b0000);
`endif

        // Randomized traffic with occasional resets.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            step();
            resetn = ($urandom_range(0, 249) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || m_xfer[i]) begin
                    if ($urandom_range(0, 99) < 60) begin
                        req_valid[i] = 1'b1;
                        set_data(i, $urandom);
                        req_last[i]  = ($urandom_range(0, 2) == 0);
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            out_ready = ($urandom_range(0, 99) < 65);
        end

        step();
        step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
